pl_if_stage: RTL

//  Instruction-fetch stage of the 5-stage MIPS pipeline, plus the IF/ID pipeline register.
//  - Owns the PC and drives the word address of the instruction memory.
//  - Latches the fetched instruction and PC+4 into IF/ID for the decode stage.
//  - Honours stall (hazard unit), flush and redirect (branch/jump resolution) from downstream.
//  - Sits directly upstream of decode inside pl_main.

---
 rtl/pl_pkg.sv | 7 +
 rtl/pl_if_stage_if.sv | 10 +
 rtl/pl_if_id_reg.sv | 29 ++
 rtl/pl_if_stage.sv | 60 ++++++
 4 files changed

// File: rtl/pl_pkg.sv
// pl_pkg: constants and types shared by the pipeline stages
package pl_pkg;
    localparam int PL_XLEN = 32;
    typedef logic [PL_XLEN-1:0] pc_t;
    localparam logic [PL_XLEN-1:0] PL_NOP = 32'h0000_0000;
    localparam pc_t PL_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/pl_if_stage_if.sv
// pl_if_stage_if: imem fetch bus plus the IF/ID register outputs toward decode
interface pl_if_stage_if #(parameter int IMEM_AW = 10);
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic if_id_valid;
    modport master (output imem_addr, if_id_instr, if_id_pc4, if_id_valid, input imem_rdata);
    modport slave (input imem_addr, if_id_instr, if_id_pc4, if_id_valid, output imem_rdata);
endinterface

// File: rtl/pl_if_id_reg.sv
// pl_if_id_reg: IF/ID register; bubble beats stall, stall beats load
module pl_if_id_reg
    import pl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic stall,
    input  logic bubble,
    input  logic [31:0] instr_in,
    input  pc_t pc4_in,
    output logic [31:0] instr,
    output pc_t pc4,
    output logic valid
);
    always_ff @(posedge clk) begin
        if (rst) begin
            instr <= PL_NOP;
            pc4 <= '0;
            valid <= 1'b0;
        end else if (bubble) begin
            instr <= PL_NOP;
            valid <= 1'b0;
        end else if (!stall) begin
            instr <= instr_in;
            pc4 <= pc4_in;
            valid <= 1'b1;
        end
    end
endmodule

// File: rtl/pl_if_stage.sv
// pl_if_stage: PC, imem addressing and IF/ID register of the MIPS pipeline.
// PL_IF_PERF_EN enables the fetch/stall perf counters (otherwise tied to 0).
module pl_if_stage
    import pl_pkg::*;
#(
    parameter pc_t RESET_PC = PL_RESET_PC,
    parameter int IMEM_AW = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    input  logic flush,
    input  logic redirect_valid,
    input  pc_t redirect_pc,
    output pc_t pc_out,
    output logic misalign_err,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    pl_if_stage_if.master bus
);
    pc_t pc, pc4;
    assign pc4 = pc + 32'd4;
    assign pc_out = pc;
    assign bus.imem_addr = pc[IMEM_AW+1:2];
    // redirect wins over stall so a resolved branch is never dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            pc <= redirect_valid ? {redirect_pc[31:2], 2'b00} : stall ? pc : pc4;
            misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end
    pl_if_id_reg u_if_id (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .bubble(flush || redirect_valid),
        .instr_in(bus.imem_rdata),
        .pc4_in(pc4),
        .instr(bus.if_id_instr),
        .pc4(bus.if_id_pc4),
        .valid(bus.if_id_valid)
    );
`ifdef PL_IF_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'(!(flush || redirect_valid || stall));
            perf_stall_cnt <= perf_stall_cnt + 32'(stall);
        end
    end
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif
endmodule
